// File: rtl/hub_sequencer.sv
// Ethernet-FireWire hub procedural sequencer: PC command / broadcast phase control with error recovery.
// Optional wait-state watchdog enabled by defining HUB_SEQ_TIMEOUT_EN.
module hub_sequencer #(
  parameter int          NODE_W   = 4,
  parameter logic [3:0]  ACK_DONE = 4'h1,
  parameter logic [3:0]  ACK_PEND = 4'h2,
  parameter int          TO_W     = 16,
  parameter int          TO_LIM   = 40000
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              mode_req,
  input  logic [NODE_W-1:0] num_node,
  input  logic              init_done,
  input  logic              pc_req_new,
  input  logic              pc_req_txed,
  input  logic              bc_req_txed,
  input  logic              ack_rxed,
  input  logic [3:0]        ack_resp,
  input  logic              resp_rxed,
  input  logic              bc_resp_rxed,
  input  logic              trans_done,
  output logic [5:0]        status,
  output logic              hub_mode,
  output logic [1:0]        eth_master,
  output logic [NODE_W-1:0] bc_cnt,
  output logic              err_pulse,
  output logic [7:0]        err_cnt
);

  typedef enum logic [5:0] {
    INIT   = 6'b000000,
    PC_RX  = 6'b110000,
    PC_FTX = 6'b100001,
    PC_ACK = 6'b100100,
    PC_RSP = 6'b100110,
    PC_ETX = 6'b111000,
    BC_FTX = 6'b100011,
    BC_ACK = 6'b100101,
    BC_COL = 6'b100111,
    BC_ETX = 6'b101000
  } state_t;

  localparam bit TO_CFG_OK = (TO_LIM > 0) && (TO_LIM < (1 << TO_W));

  state_t            state, state_nx;
  logic              mode_nx, err_nx, bc_exit, to_hit;
  logic [NODE_W-1:0] cnt_nx, bc_lim, lim_nx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign status = state;

  // Ethernet owner decode: bit5 clear is init, bit3 marks the Ethernet TX states
  always_comb begin
    eth_master = 2'b11;
    if (!status[5])     eth_master = 2'b00;
    else if (status[3]) eth_master = 2'b01;
    else if (status[4]) eth_master = 2'b10;
  end

`ifdef HUB_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] timer;
  logic            counting;

  always_comb counting = state inside {PC_FTX, PC_ACK, PC_RSP, BC_FTX, BC_ACK, BC_COL};
  assign to_hit = counting && (timer == TO_W'(TO_LIM - 1));

  always_ff @(posedge sysclk) begin
    if (!reset)                               timer <= '0;
    else if ((state_nx != state) || !counting) timer <= '0;
    else                                      timer <= timer + TO_W'(1);
  end
`else
  assign to_hit = 1'b0 & TO_CFG_OK;
`endif

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state     <= INIT;
      hub_mode  <= mode_req;
      bc_cnt    <= '0;
      bc_lim    <= NODE_W'(1);
      err_pulse <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      state     <= state_nx;
      hub_mode  <= mode_nx;
      bc_cnt    <= cnt_nx;
      bc_lim    <= lim_nx;
      err_pulse <= err_nx;
      if (err_nx) err_cnt <= sat_inc(err_cnt);
    end
  end

  always_comb begin
    state_nx = state;
    mode_nx  = hub_mode;
    cnt_nx   = bc_cnt;
    lim_nx   = bc_lim;
    err_nx   = 1'b0;
    bc_exit  = 1'b0;
    case (state)
      INIT:   if (init_done) state_nx = hub_mode ? BC_FTX : PC_RX;
      PC_RX: begin
        if (pc_req_new) state_nx = PC_FTX;
        else if (mode_req) begin
          state_nx = BC_FTX;
          mode_nx  = 1'b1;
        end
      end
      PC_FTX: begin
        if (pc_req_txed) state_nx = PC_ACK;
        else if (to_hit) begin err_nx = 1'b1; state_nx = PC_RX; end
      end
      PC_ACK: begin
        if (ack_rxed) begin
          if (ack_resp == ACK_DONE)      state_nx = PC_RX;
          else if (ack_resp == ACK_PEND) state_nx = PC_RSP;
          else begin err_nx = 1'b1; state_nx = PC_RX; end
        end else if (to_hit) begin err_nx = 1'b1; state_nx = PC_RX; end
      end
      PC_RSP: begin
        if (resp_rxed) state_nx = PC_ETX;
        else if (to_hit) begin err_nx = 1'b1; state_nx = PC_RX; end
      end
      PC_ETX: if (trans_done) state_nx = PC_RX;
      BC_FTX: begin
        if (bc_req_txed) state_nx = BC_ACK;
        else if (to_hit) begin err_nx = 1'b1; bc_exit = 1'b1; end
      end
      BC_ACK: begin
        if (ack_rxed && (ack_resp == ACK_DONE)) begin
          state_nx = BC_COL;
          cnt_nx   = '0;
          lim_nx   = (num_node == '0) ? NODE_W'(1) : num_node;
        end else if (ack_rxed || to_hit) begin
          err_nx  = 1'b1;
          bc_exit = 1'b1;
        end
      end
      BC_COL: begin
        if (bc_resp_rxed) begin
          cnt_nx = bc_cnt + NODE_W'(1);
          if (cnt_nx == bc_lim) state_nx = BC_ETX;
        end else if (to_hit) begin err_nx = 1'b1; bc_exit = 1'b1; end
      end
      BC_ETX: if (trans_done) bc_exit = 1'b1;
      default: state_nx = INIT;
    endcase
    // End of a broadcast cycle is the only point besides PC_RX where mode_req is honoured
    if (bc_exit) begin
      if (mode_req) state_nx = BC_FTX;
      else begin
        state_nx = PC_RX;
        mode_nx  = 1'b0;
      end
    end
  end

endmodule
